adc_average_multi: RTL and testbench
====================================

# adc_average_multi

Multi-channel block averager for the SPGD ADC front end, parametrised in sample width, channel count and power-of-two block length. Accumulates `2^LOG2_SAMPS` valid samples per channel in signed arithmetic, then presents the per-channel mean with a one-cycle `OUT_VALID` strobe. Supports one-shot and continuous (back-to-back block) operation, plus abort/restart. Sits between the ADC capture interface and the SPGD metric computation.

## Interface
- `ADC_WIDTH`, 12: signed sample width per channel.
- `NUM_CH`, 2: number of channels, ≥1.
- `LOG2_SAMPS`, 10: block length is N = 2^LOG2_SAMPS, range 1..16.
- `CLK` in 1: single clock; all logic on rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: begin a block, or abort and restart an active one.
- `CONT` in 1: continuous mode; sampled at each block end.
- `IN_VALID` in 1: `DATA_IN` holds a valid sample set this cycle.
- `DATA_IN` in NUM_CH*ADC_WIDTH: channel c occupies bits [c*ADC_WIDTH +: ADC_WIDTH], two's complement.
- `BUSY` out 1: high in ACCUM.
- `OUT_VALID` out 1: one-cycle strobe, new `DATA_OUT` present.
- `DATA_OUT` out NUM_CH*ADC_WIDTH: per-channel mean, same packing as `DATA_IN`; held until next strobe.

## Operation
- States: IDLE, ACCUM. Sample counter width LOG2_SAMPS+1. Accumulators: one per channel, ADC_WIDTH+LOG2_SAMPS bits, signed.
- IDLE: `IN_VALID` ignored. `START`=1 → ACCUM with count 0 and accumulators cleared. If `IN_VALID`=1 in the same cycle, that sample is loaded as sample 1: count=1, acc=sign-extended `DATA_IN`.
- ACCUM: each cycle with `IN_VALID`=1, every acc += sign-extended channel sample and count increments. Cycles with `IN_VALID`=0 hold the state.
- Block end is the cycle the Nth sample is accepted. On that edge:
  - `DATA_OUT[c]` ← acc_final[c] >>> LOG2_SAMPS (arithmetic shift, i.e. floor).
  - `OUT_VALID` is driven to 1 for exactly one cycle.
  - If `CONT`=1: stay in ACCUM with count 0 and acc cleared. The next valid sample starts the new block, with no gap.
  - If `CONT`=0: go to IDLE.
- `START`=1 in ACCUM aborts the current block. No `OUT_VALID` is produced, and the block restarts exactly as from IDLE, with the same-cycle sample rule above. `START` on the block-end cycle takes priority: no strobe is produced and the block restarts.
- The sum cannot overflow: |acc| ≤ 2^(ADC_WIDTH-1)·N fits in ADC_WIDTH+LOG2_SAMPS bits.

## Timing
- Reset values: `BUSY`=0, `OUT_VALID`=0, `DATA_OUT`=0, state IDLE, count=0, acc=0. Async assert; deassertion is synchronous to `CLK` (synchronizer upstream).
- Reset mid-block discards the partial sum and produces no strobe.
- Latency: `OUT_VALID` and new `DATA_OUT` are registered and appear the cycle after the edge that accepts the Nth sample.
- `BUSY` rises the cycle after `START`. It falls the cycle after the final sample when `CONT`=0, coincident with `OUT_VALID`.
- Continuous mode throughput: one result per N valid samples, with no lost samples across block boundaries.
- `DATA_OUT` changes only on an `OUT_VALID` cycle.

## Configuration
- `ADC_AVG_ROUND_EN` defined: before the shift, add 2^(LOG2_SAMPS-1) to each acc, giving round-half-up.
  - The adder is one bit wider internally; the result is saturated to [−2^(ADC_WIDTH-1), 2^(ADC_WIDTH-1)−1].
- Not defined: pure arithmetic-shift floor with no rounding adder.
- Latency is identical in both builds.

## Test plan
- Reset defaults: assert `RST_N`=0 mid-ACCUM with acc non-zero → all outputs 0 immediately and no strobe. Release, pulse `START`, feed N=4 (LOG2_SAMPS=2) samples of 100 → `DATA_OUT`=100 on ch0.
- Signed floor/round: LOG2_SAMPS=2, NUM_CH=2; ch0 samples {−1,−1,−1,0}, ch1 {1,1,1,0}.
  - Without macro → ch0=−1, ch1=0.
  - With `ADC_AVG_ROUND_EN` → ch0=−1, ch1=1.
- Extremes: LOG2_SAMPS=10, all samples 2047 → 2047; all samples −2048 → −2048, in both builds.
- Gapped valid: N=4 samples spread over 11 cycles with `IN_VALID` toggling → exactly one `OUT_VALID`, 1 cycle after the 4th accepted sample.
- Continuous: `CONT`=1, 12 consecutive valid samples, values 0..11, N=4 → three strobes with means 1, 5, 9 (floor); no sample dropped at boundaries. Drop `CONT` during block 3 → `BUSY`=0 after strobe 3.
- Abort: `START` re-pulsed with the 3rd sample of a block, sample=40, earlier samples 1000 → no strobe. The new block counts 40 as sample 1; with 3 further samples of 40, result 40.

Source files
------------

// File: rtl/adc_average_multi.sv
// adc_average_multi: multi-channel block averager, 2^LOG2_SAMPS samples/block.
// Optional build macro: ADC_AVG_ROUND_EN (round-half-up with saturation).
//
// Ports:
//   CLK, RST_N   clock, async active-low reset
//   START        begin a block, or abort and restart the active one
//   CONT         continuous mode, sampled on the block-end cycle
//   IN_VALID     DATA_IN carries a valid sample set
//   DATA_IN      NUM_CH packed two's complement samples
//   BUSY         high while accumulating
//   OUT_VALID    one-cycle strobe, new DATA_OUT present
//   DATA_OUT     NUM_CH packed per-channel means, held between strobes
module adc_average_multi #(
    parameter int ADC_WIDTH  = 12,
    parameter int NUM_CH     = 2,
    parameter int LOG2_SAMPS = 10
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        START,
    input  logic                        CONT,
    input  logic                        IN_VALID,
    input  logic [NUM_CH*ADC_WIDTH-1:0] DATA_IN,
    output logic                        BUSY,
    output logic                        OUT_VALID,
    output logic [NUM_CH*ADC_WIDTH-1:0] DATA_OUT
);

    localparam int AW = ADC_WIDTH + LOG2_SAMPS;
    localparam int CW = LOG2_SAMPS + 1;
    localparam logic [CW-1:0] N_LAST = CW'(1) << LOG2_SAMPS;

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_e;

    state_e                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [CW-1:0]               cnt_inc;
    logic signed [AW-1:0]        acc_q [NUM_CH];
    logic signed [AW-1:0]        acc_d [NUM_CH];
    logic signed [AW-1:0]        sum   [NUM_CH];
    logic signed [AW-1:0]        smp   [NUM_CH];
    logic [NUM_CH*ADC_WIDTH-1:0] dout_q, dout_d;
    logic                        ovalid_q, ovalid_d;

`ifdef ADC_AVG_ROUND_EN
    // One extra bit so adding the half-LSB can never wrap.
    localparam int RW = AW + 1;
    localparam logic signed [RW-1:0] HALF = RW'(1) << (LOG2_SAMPS - 1);
    localparam logic signed [RW-1:0] MAXV = (RW'(1) << (ADC_WIDTH - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MINV = -(RW'(1) << (ADC_WIDTH - 1));

    function automatic logic [ADC_WIDTH-1:0] mean_of(
        input logic signed [AW-1:0] s
    );
        logic signed [RW-1:0] w;
        logic signed [RW-1:0] sh;
        w  = $signed({s[AW-1], s}) + HALF;
        sh = w >>> LOG2_SAMPS;
        if (sh > MAXV) begin
            sh = MAXV;
        end else if (sh < MINV) begin
            sh = MINV;
        end
        return sh[ADC_WIDTH-1:0];
    endfunction
`else
    // Dropping the low bits of a two's complement sum is a floor divide.
    function automatic logic [ADC_WIDTH-1:0] mean_of(
        input logic signed [AW-1:0] s
    );
        return s[AW-1:LOG2_SAMPS];
    endfunction
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            smp[c] = {{LOG2_SAMPS{DATA_IN[c*ADC_WIDTH+ADC_WIDTH-1]}},
                      DATA_IN[c*ADC_WIDTH +: ADC_WIDTH]};
            sum[c] = acc_q[c] + smp[c];
        end
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dout_d   = dout_q;
        ovalid_d = 1'b0;

        if (START) begin
            // Start and abort share one path; a same-cycle sample is sample 1.
            state_d = S_ACCUM;
            cnt_d   = IN_VALID ? CW'(1) : '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_d[c] = IN_VALID ? smp[c] : '0;
            end
        end else if (state_q == S_ACCUM && IN_VALID) begin
            if (cnt_inc == N_LAST) begin
                ovalid_d = 1'b1;
                cnt_d    = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    dout_d[c*ADC_WIDTH +: ADC_WIDTH] = mean_of(sum[c]);
                    acc_d[c] = '0;
                end
                if (!CONT) begin
                    state_d = S_IDLE;
                end
            end else begin
                cnt_d = cnt_inc;
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign BUSY      = (state_q == S_ACCUM);
    assign OUT_VALID = ovalid_q;
    assign DATA_OUT  = dout_q;

endmodule

// File: tb/tb_adc_average_multi.sv
// tb_adc_average_multi: vectors, corner sequences and random stimulus
// for adc_average_multi, checked against a sample-queue reference model.
module tb_adc_average_multi;

    localparam int W  = 12;
    localparam int NS = 4;
    localparam int NB = 1024;

`ifdef ADC_AVG_ROUND_EN
    localparam int F0 = -1, F1 = 1;
    localparam int C1A = 2, C1B = -1;
    localparam int C2A = 6, C2B = -5;
    localparam int C3A = 10, C3B = -9;
    localparam int GAP = 9;
`else
    localparam int F0 = -1, F1 = 0;
    localparam int C1A = 1, C1B = -2;
    localparam int C2A = 5, C2B = -6;
    localparam int C3A = 9, C3B = -10;
    localparam int GAP = 8;
`endif

    logic          CLK, RST_N;
    logic          START, CONT, IN_VALID;
    logic [2*W-1:0] DATA_IN;
    logic          BUSY, OUT_VALID;
    logic [2*W-1:0] DATA_OUT;

    logic          b_start, b_cont, b_valid;
    logic [2*W-1:0] b_din;
    logic          b_busy, b_ov;
    logic [2*W-1:0] b_dout;

    adc_average_multi #(.ADC_WIDTH(W), .NUM_CH(2), .LOG2_SAMPS(2)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .CONT(CONT),
        .IN_VALID(IN_VALID), .DATA_IN(DATA_IN), .BUSY(BUSY),
        .OUT_VALID(OUT_VALID), .DATA_OUT(DATA_OUT)
    );

    adc_average_multi #(.ADC_WIDTH(W), .NUM_CH(2), .LOG2_SAMPS(10)) u_big (
        .CLK(CLK), .RST_N(RST_N), .START(b_start), .CONT(b_cont),
        .IN_VALID(b_valid), .DATA_IN(b_din), .BUSY(b_busy),
        .OUT_VALID(b_ov), .DATA_OUT(b_dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: collect the block's samples, average on completion.
    bit m_act;
    bit m_ov;
    int m_o0, m_o1;
    int q0[$], q1[$];

    function automatic longint floor_div(longint a, longint n);
        if (a >= 0) return a / n;
        return -((-a + n - 1) / n);
    endfunction

    function automatic int ref_mean(longint s, int n);
        longint r;
`ifdef ADC_AVG_ROUND_EN
        r = floor_div(s + n / 2, n);
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
`else
        r = floor_div(s, n);
`endif
        return int'(r);
    endfunction

    task automatic model_reset();
        m_act = 0; m_ov = 0; m_o0 = 0; m_o1 = 0;
        q0.delete(); q1.delete();
    endtask

    task automatic model(bit st, bit ct, bit vl, int d0, int d1);
        longint s0, s1;
        m_ov = 0;
        if (st) begin
            m_act = 1;
            q0.delete(); q1.delete();
            if (vl) begin
                q0.push_back(d0); q1.push_back(d1);
            end
        end else if (m_act && vl) begin
            q0.push_back(d0); q1.push_back(d1);
            if (q0.size() == NS) begin
                s0 = 0; s1 = 0;
                foreach (q0[i]) s0 += q0[i];
                foreach (q1[i]) s1 += q1[i];
                m_o0 = ref_mean(s0, NS);
                m_o1 = ref_mean(s1, NS);
                m_ov = 1;
                q0.delete(); q1.delete();
                m_act = ct;
            end
        end
    endtask

    task automatic step(bit st, bit ct, bit vl, int d0, int d1);
        START = st; CONT = ct; IN_VALID = vl;
        DATA_IN = {12'(d1), 12'(d0)};
        @(posedge CLK); #1;
        model(st, ct, vl, d0, d1);
        if (OUT_VALID) strobes++;
        chk("busy", BUSY, m_busy());
        chk("out_valid", OUT_VALID, m_ov);
        chk("dout_ch0", $signed(DATA_OUT[W-1:0]), m_o0);
        chk("dout_ch1", $signed(DATA_OUT[2*W-1:W]), m_o1);
    endtask

    function automatic bit m_busy();
        return m_act;
    endfunction

    typedef struct {
        bit st; bit ct; bit vl; int d0; int d1;
        bit e_bz; bit e_ov; int e0; int e1;
    } vec_t;
    vec_t vt[$];

    task automatic add(bit st, bit ct, bit vl, int d0, int d1,
                       bit bz, bit ov, int e0, int e1);
        vec_t v;
        v = '{st, ct, vl, d0, d1, bz, ov, e0, e1};
        vt.push_back(v);
    endtask

    task automatic big_block(int v);
        b_start = 1; b_cont = 0; b_valid = 1;
        b_din = {12'(v), 12'(v)};
        @(posedge CLK); #1;
        b_start = 0;
        repeat (NB - 2) @(posedge CLK);
        #1;
        chk("big_early", b_ov, 1'b0);
        @(posedge CLK); #1;
        b_valid = 0;
        chk("big_ov", b_ov, 1'b1);
        chk("big_ch0", $signed(b_dout[W-1:0]), v);
        chk("big_ch1", $signed(b_dout[2*W-1:W]), v);
        chk("big_busy", b_busy, 1'b0);
    endtask

    initial begin
        int s;
        START = 0; CONT = 0; IN_VALID = 0; DATA_IN = '0;
        b_start = 0; b_cont = 0; b_valid = 0; b_din = '0;
        RST_N = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ov", OUT_VALID, 1'b0);
        chk("rst_dout", DATA_OUT, 0);
        chk("rst_big_busy", b_busy, 1'b0);
        RST_N = 1;

        // Signed floor/round block, then an ignored sample in IDLE.
        add(1, 0, 1, -1, 1, 1, 0, 0, 0);
        add(0, 0, 1, -1, 1, 1, 0, 0, 0);
        add(0, 0, 1, -1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1, F0, F1);
        add(0, 0, 1, 5, 5, 0, 0, F0, F1);
        // Continuous 0..11, CONT dropped in block 3.
        for (int i = 0; i < 12; i++) begin
            int e0, e1;
            if (i < 3) begin e0 = F0; e1 = F1; end
            else if (i < 7) begin e0 = C1A; e1 = C1B; end
            else if (i < 11) begin e0 = C2A; e1 = C2B; end
            else begin e0 = C3A; e1 = C3B; end
            add(i == 0, i < 8, 1, i, -i, i != 11,
                i == 3 || i == 7 || i == 11, e0, e1);
        end
        add(0, 0, 0, 0, 0, 0, 0, C3A, C3B);

        foreach (vt[i]) begin
            step(vt[i].st, vt[i].ct, vt[i].vl, vt[i].d0, vt[i].d1);
            chk("tbl_busy", BUSY, vt[i].e_bz);
            chk("tbl_ov", OUT_VALID, vt[i].e_ov);
            chk("tbl_ch0", $signed(DATA_OUT[W-1:0]), vt[i].e0);
            chk("tbl_ch1", $signed(DATA_OUT[2*W-1:W]), vt[i].e1);
        end

        // Gapped valid: 4 samples over 11 cycles.
        begin
            bit pat [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
            int v = 7;
            int nv = 0;
            step(1, 0, 0, 0, 0);
            strobes = 0;
            for (int i = 0; i < 11; i++) begin
                step(0, 0, pat[i], v, -v);
                if (pat[i]) begin
                    v++;
                    nv++;
                    if (nv == 4) begin
                        chk("gap_pos", OUT_VALID, 1'b1);
                        chk("gap_ch0", $signed(DATA_OUT[W-1:0]), GAP);
                    end
                end
            end
            chk("gap_strobes", strobes, 1);
        end

        // Abort with the 3rd sample; new block starts from it.
        strobes = 0;
        step(1, 0, 1, 1000, -1000);
        step(0, 0, 1, 1000, -1000);
        step(1, 0, 1, 40, -40);
        step(0, 0, 1, 40, -40);
        step(0, 0, 1, 40, -40);
        chk("abort_nostrobe", strobes, 0);
        step(0, 0, 1, 40, -40);
        chk("abort_ov", OUT_VALID, 1'b1);
        chk("abort_ch0", $signed(DATA_OUT[W-1:0]), 40);
        chk("abort_ch1", $signed(DATA_OUT[2*W-1:W]), -40);

        // Extremes on the 1024-sample instance.
        START = 0; IN_VALID = 0;
        big_block(2047);
        big_block(-2048);

        // Random traffic against the model.
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            int a, b;
            a = int'($urandom_range(0, 4095)) - 2048;
            b = int'($urandom_range(0, 4095)) - 2048;
            if ($urandom_range(0, 9) == 0) a = 2047;
            if ($urandom_range(0, 9) == 0) b = -2048;
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, a, b);
        end

        // Known non-zero result, then reset mid-block.
        step(1, 0, 1, 5, 5);
        for (s = 0; s < 3; s++) step(0, 0, 1, 5, 5);
        step(1, 0, 1, 100, 100);
        step(0, 0, 1, 100, 100);
        #2 RST_N = 0;
        #1;
        model_reset();
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_ov", OUT_VALID, 1'b0);
        chk("midrst_dout", DATA_OUT, 0);
        @(posedge CLK); #1;
        chk("midrst_ov2", OUT_VALID, 1'b0);
        RST_N = 1;
        step(0, 0, 1, 100, 100);
        chk("post_rst_idle", BUSY, 1'b0);
        step(1, 0, 1, 100, 100);
        step(0, 0, 1, 100, 100);
        step(0, 0, 1, 100, 100);
        step(0, 0, 1, 100, 100);
        chk("post_rst_ov", OUT_VALID, 1'b1);
        chk("post_rst_ch0", $signed(DATA_OUT[W-1:0]), 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
